fft_hdmi_writer: RTL and testbench
==================================

FFT_HDMI_WRITER -- requirements
Module: fft_hdmi_writer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports are named wr_clk and wr_rst, matching the write side of the FFT-to-HDMI FIFO this block feeds.
REQ-002 Parameters (name, default, meaning):
- NUM_BINS, 512, bins written per frame (the lower half-spectrum of a 1024-point FFT).
- LEVEL_LIMIT, 512, highest fifo_level value at frame start that still admits the frame.
REQ-003 Ports (name, direction, width, meaning):
- wr_clk, in, 1, clock.
- wr_rst, in, 1, async active-high reset.
- s_valid, in, 1, FFT output beat valid; there is no backpressure.
- s_last, in, 1, last beat of FFT frame.
- s_re, in, 16, signed real part.
- s_im, in, 16, signed imaginary part.
- fifo_full, in, 1, FIFO full flag.
- fifo_level, in, 11, FIFO write water level.
- fifo_wr_en, out, 1, FIFO write enable.
- fifo_wr_data, out, 16, magnitude word.
- frame_drop, out, 1, one-cycle pulse: whole frame discarded.
- frame_err, out, 1, one-cycle pulse: s_last arrived before NUM_BINS beats.
- overflow, out, 1, one-cycle pulse: a beat was lost to fifo_full.

Function
REQ-004 Magnitude SHALL be computed as mag = max(|re|,|im|) + (min(|re|,|im|) >> 2), unsigned 17-bit internal; |-32768| = 32768.
REQ-005 Pipeline: stage 1 registers abs/max/min; stage 2 registers the sum and the write. fifo_wr_en for an accepted beat SHALL assert exactly 2 cycles after that s_valid beat.
REQ-006 A beat counter bin_idx SHALL increment on each s_valid, clear to 0 after a beat with s_last, and saturate at NUM_BINS. Beats with bin_idx >= NUM_BINS SHALL NOT be written.
REQ-007 FSM states: IDLE, WRITE, DROP.
- IDLE: on s_valid with bin_idx==0, go to WRITE if fifo_level <= LEVEL_LIMIT, else DROP.
- WRITE and DROP: return to IDLE on s_valid&&s_last.
- The admission decision SHALL apply to the first beat itself.
REQ-008 DROP SHALL write nothing; frame_drop SHALL pulse the cycle after the DROP entry decision.
REQ-009 In WRITE, if fifo_full is high in the cycle fifo_wr_en would assert, the write SHALL be suppressed and overflow SHALL pulse that cycle; the frame continues.
REQ-010 If s_last arrives with bin_idx < NUM_BINS-1, frame_err SHALL pulse one cycle later; no padding is written; the FSM returns to IDLE.
REQ-011 A new frame's first beat SHALL be accepted in the cycle immediately following the previous s_last (back-to-back frames, no bubble).
REQ-012 fifo_wr_data SHALL hold its last value when fifo_wr_en is low.

Reset
REQ-013 On wr_rst high, all outputs SHALL be 0, the FSM SHALL be in IDLE, bin_idx SHALL be 0, and the pipeline SHALL be flushed; no write issues from pre-reset beats.
REQ-014 After wr_rst deasserts mid-frame, the remaining beats SHALL be treated as a new frame starting at bin 0; alignment is restored by the next s_last.

Configuration
REQ-015 Macro FFT_HDMI_SOF_MARK_EN:
- Defined: the magnitude SHALL be saturated to 15 bits (max 32767), and fifo_wr_data[15] SHALL be 1 only for bin 0 of each written frame.
- Undefined: fifo_wr_data SHALL be mag saturated to 16 bits, with no marker.

Verification
REQ-016 Single frame, fifo_level=0, 1024 beats re=3000 im=-4000 -> 512 writes of 4750 (without macro), first write 2 cycles after the first beat, no pulses.
REQ-017 fifo_level=600 at the first beat -> 0 writes for that frame, frame_drop pulse once; next frame with level 0 -> 512 writes.
REQ-018 re=-32768 im=-32768 -> 40960 without macro; with macro, bin0 word = 0xFFFF and other bins = 0x7FFF.
REQ-019 s_last on the 300th beat -> 300 writes, frame_err pulse, next frame starts at bin 0; back-to-back frames -> 512+512 writes with no gap.
REQ-020 fifo_full forced high for 3 cycles mid-WRITE -> 3 writes missing, 3 overflow pulses; wr_rst asserted mid-frame -> outputs 0 within the same cycle, no stale writes afterward.

Source files
------------

// File: rtl/fft_hdmi_writer.sv
// ============================================================================
// Module   : fft_hdmi_writer
// Purpose  : Converts FFT output beats into alpha-max/beta-min magnitude words
//            and writes the lower half-spectrum of each frame into the HDMI
//            FIFO. Frames are admitted or dropped by FIFO level at frame start.
// Option   : FFT_HDMI_SOF_MARK_EN -- 15-bit magnitude, bit 15 flags bin 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_hdmi_writer #(
  parameter int unsigned NUM_BINS    = 512,
  parameter int unsigned LEVEL_LIMIT = 512
) (
  input  logic               wr_clk,
  input  logic               wr_rst,
  input  logic               s_valid,
  input  logic               s_last,
  input  logic signed [15:0] s_re,
  input  logic signed [15:0] s_im,
  input  logic               fifo_full,
  input  logic [10:0]        fifo_level,
  output logic               fifo_wr_en,
  output logic [15:0]        fifo_wr_data,
  output logic               frame_drop,
  output logic               frame_err,
  output logic               overflow
);

  localparam int unsigned        c_bin_w       = $clog2(NUM_BINS + 1);
  localparam logic [c_bin_w-1:0] c_num_bins    = c_bin_w'(NUM_BINS);
  localparam logic [c_bin_w-1:0] c_last_bin    = c_bin_w'(NUM_BINS - 1);
  localparam logic [11:0]        c_level_limit = 12'(LEVEL_LIMIT);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_write = 2'd1;
  localparam logic [1:0] c_st_drop  = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_bin_w-1:0] r_bin_idx;
  logic               w_level_ok;
  logic               w_first;
  logic               w_accept;
  logic               w_drop_dec;

  logic [16:0] w_re_ext;
  logic [16:0] w_im_ext;
  logic [16:0] w_abs_re;
  logic [16:0] w_abs_im;
  logic [16:0] w_max;
  logic [16:0] w_min;
  logic [16:0] w_sum;
  logic [15:0] w_word;

  logic [16:0] r_s1_max;
  logic [16:0] r_s1_min;
  logic        r_s1_vld;
  logic        r_s2_vld;
  logic [15:0] r_s2_data;
  logic [15:0] r_hold;
  logic        r_frame_drop;
  logic        r_frame_err;

  assign w_level_ok = ({1'b0, fifo_level} <= c_level_limit);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        // A single-beat frame completes in the same cycle it is admitted.
        if (s_valid && (r_bin_idx == '0) && !s_last) begin
          w_state_nxt = w_level_ok ? c_st_write : c_st_drop;
        end
      end
      c_st_write,
      c_st_drop: begin
        if (s_valid && s_last) begin
          w_state_nxt = c_st_idle;
        end
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    w_first    = s_valid && (r_state == c_st_idle) && (r_bin_idx == '0);
    w_drop_dec = w_first && !w_level_ok;
    w_accept   = s_valid && (r_bin_idx < c_num_bins) &&
                 ((r_state == c_st_write) || (w_first && w_level_ok));
  end

  // ---------------------------------------------------------------- bin counter
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      r_bin_idx <= '0;
    end else if (s_valid) begin
      if (s_last) begin
        r_bin_idx <= '0;
      end else if (r_bin_idx < c_num_bins) begin
        r_bin_idx <= r_bin_idx + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- magnitude
  always_comb begin
    w_re_ext = {s_re[15], s_re};
    w_im_ext = {s_im[15], s_im};
    w_abs_re = s_re[15] ? (~w_re_ext + 17'd1) : w_re_ext;
    w_abs_im = s_im[15] ? (~w_im_ext + 17'd1) : w_im_ext;
    if (w_abs_re >= w_abs_im) begin
      w_max = w_abs_re;
      w_min = w_abs_im;
    end else begin
      w_max = w_abs_im;
      w_min = w_abs_re;
    end
  end

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      r_s1_max <= '0;
      r_s1_min <= '0;
      r_s1_vld <= 1'b0;
    end else begin
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_max <= w_max;
        r_s1_min <= w_min;
      end
    end
  end

  assign w_sum = r_s1_max + (r_s1_min >> 2);

`ifdef FFT_HDMI_SOF_MARK_EN
  logic r_s1_first;

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      r_s1_first <= 1'b0;
    end else if (w_accept) begin
      r_s1_first <= (r_bin_idx == '0);
    end
  end

  always_comb begin
    w_word = {r_s1_first, (w_sum > 17'd32767) ? 15'h7FFF : w_sum[14:0]};
  end
`else
  always_comb begin
    w_word = w_sum[16] ? 16'hFFFF : w_sum[15:0];
  end
`endif

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      r_s2_vld  <= 1'b0;
      r_s2_data <= '0;
    end else begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_data <= w_word;
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  // Full is gated in the write cycle itself so a suppressed word never lands.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      r_hold       <= '0;
      r_frame_drop <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      if (fifo_wr_en) begin
        r_hold <= r_s2_data;
      end
      r_frame_drop <= w_drop_dec;
      r_frame_err  <= s_valid && s_last && (r_bin_idx < c_last_bin);
    end
  end

  assign fifo_wr_en   = r_s2_vld && !fifo_full;
  assign overflow     = r_s2_vld && fifo_full;
  assign fifo_wr_data = fifo_wr_en ? r_s2_data : r_hold;
  assign frame_drop   = r_frame_drop;
  assign frame_err    = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_fft_hdmi_writer.sv
// ============================================================================
// Module   : tb_fft_hdmi_writer
// Purpose  : Self-checking bench for fft_hdmi_writer using a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fft_hdmi_writer;

  localparam int NB  = 512;
  localparam int LIM = 512;

  logic               wr_clk = 1'b0;
  logic               wr_rst;
  logic               s_valid;
  logic               s_last;
  logic signed [15:0] s_re;
  logic signed [15:0] s_im;
  logic               fifo_full;
  logic [10:0]        fifo_level;
  logic               fifo_wr_en;
  logic [15:0]        fifo_wr_data;
  logic               frame_drop;
  logic               frame_err;
  logic               overflow;

  fft_hdmi_writer #(.NUM_BINS(NB), .LEVEL_LIMIT(LIM)) dut (
    .wr_clk      (wr_clk),
    .wr_rst      (wr_rst),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_re        (s_re),
    .s_im        (s_im),
    .fifo_full   (fifo_full),
    .fifo_level  (fifo_level),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .frame_drop  (frame_drop),
    .frame_err   (frame_err),
    .overflow    (overflow)
  );

  always #5 wr_clk = ~wr_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: frame position, admission, and per-cycle expected events.
  int m_bin    = 0;
  bit m_admit  = 0;
  int m_last   = 0;
  int cyc      = 0;
  bit sch_wr[4];
  int sch_data[4];
  bit sch_drop[4];
  bit sch_err[4];

  int wr_cnt, ovf_cnt, drop_cnt, err_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int model_mag(input int re, input int im, input bit first);
    int a, b, mx, mn, m;
    a  = (re < 0) ? -re : re;
    b  = (im < 0) ? -im : im;
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    m  = mx + mn / 4;
`ifdef FFT_HDMI_SOF_MARK_EN
    if (m > 32767) m = 32767;
    if (first) m = m + 32768;
`else
    if (m > 65535) m = 65535;
    if (first) m = m + 0;
`endif
    return m;
  endfunction

  task automatic clear_counts();
    wr_cnt = 0; ovf_cnt = 0; drop_cnt = 0; err_cnt = 0;
  endtask

  // One clock cycle: apply inputs, update the model, check outputs mid-cycle.
  task automatic step(input bit rst, input bit v, input bit l, input int re,
                      input int im, input int lvl, input bit full);
    int  slot;
    bit  exp_en;
    int  exp_data;
    slot       = cyc % 4;
    wr_rst     = rst;
    s_valid    = v;
    s_last     = l;
    s_re       = 16'(re);
    s_im       = 16'(im);
    fifo_level = 11'(lvl);
    fifo_full  = full;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        sch_wr[i] = 0; sch_drop[i] = 0; sch_err[i] = 0;
      end
      m_bin = 0; m_admit = 0; m_last = 0;
    end else if (v) begin
      if (m_bin == 0) begin
        m_admit = (lvl <= LIM);
        if (!m_admit) sch_drop[(cyc + 1) % 4] = 1;
      end
      if (m_admit && m_bin < NB) begin
        sch_wr[(cyc + 2) % 4]   = 1;
        sch_data[(cyc + 2) % 4] = model_mag(re, im, m_bin == 0);
      end
      if (l) begin
        if (m_bin < NB - 1) sch_err[(cyc + 1) % 4] = 1;
        m_bin = 0;
      end else if (m_bin < NB) begin
        m_bin++;
      end
    end
    @(negedge wr_clk);
    exp_en   = sch_wr[slot] && !full;
    exp_data = exp_en ? sch_data[slot] : m_last;
    check_eq("wr_en",    32'(fifo_wr_en),   32'(exp_en));
    check_eq("overflow", 32'(overflow),     32'(sch_wr[slot] && full));
    check_eq("drop",     32'(frame_drop),   32'(sch_drop[slot]));
    check_eq("err",      32'(frame_err),    32'(sch_err[slot]));
    check_eq("wr_data",  32'(fifo_wr_data), 32'(exp_data));
    if (fifo_wr_en === 1'b1) wr_cnt++;
    if (overflow === 1'b1)   ovf_cnt++;
    if (frame_drop === 1'b1) drop_cnt++;
    if (frame_err === 1'b1)  err_cnt++;
    if (exp_en) m_last = sch_data[slot];
    sch_wr[slot] = 0; sch_drop[slot] = 0; sch_err[slot] = 0;
    cyc++;
    @(posedge wr_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Contiguous frame of n beats; fifo_full high for beats [fa, fa+fl).
  task automatic frame(input int n, input int lvl, input int re, input int im,
                       input int fa, input int fl);
    for (int i = 0; i < n; i++)
      step(0, 1, i == n - 1, re, im, lvl, (i >= fa) && (i < fa + fl));
  endtask

  int exp_hold;

  initial begin
    for (int i = 0; i < 4; i++) begin
      sch_wr[i] = 0; sch_data[i] = 0; sch_drop[i] = 0; sch_err[i] = 0;
    end
    clear_counts();
    wr_rst = 1; s_valid = 0; s_last = 0; s_re = 0; s_im = 0;
    fifo_full = 0; fifo_level = 0;
    #1;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Single long frame: only the first NB beats are written.
    clear_counts();
    frame(1024, 0, 3000, -4000, -1, 0);
    idle(3);
    check_eq("t1_writes", 32'(wr_cnt), 32'd512);
    check_eq("t1_pulses", 32'(drop_cnt + err_cnt + ovf_cnt), 32'd0);
    check_eq("t1_hold",   32'(fifo_wr_data), 32'd4750);

    // High level drops the frame, next frame admitted.
    clear_counts();
    frame(512, 600, 1000, 2000, -1, 0);
    idle(3);
    check_eq("t2_drop_writes", 32'(wr_cnt), 32'd0);
    check_eq("t2_drop_pulse",  32'(drop_cnt), 32'd1);
    clear_counts();
    frame(512, 0, 1000, 2000, -1, 0);
    idle(3);
    check_eq("t2_next_writes", 32'(wr_cnt), 32'd512);

    // Full-scale negative input.
    clear_counts();
    frame(512, 0, -32768, -32768, -1, 0);
    idle(3);
`ifdef FFT_HDMI_SOF_MARK_EN
    exp_hold = 32767;
`else
    exp_hold = 40960;
`endif
    check_eq("t3_hold", 32'(fifo_wr_data), 32'(exp_hold));

    // Short frame, then back-to-back full frames.
    clear_counts();
    frame(300, 0, 123, -456, -1, 0);
    frame(512, 0, -777, 55, -1, 0);
    frame(512, 0, 20000, 20000, -1, 0);
    idle(3);
    check_eq("t4_writes", 32'(wr_cnt), 32'd1324);
    check_eq("t4_err",    32'(err_cnt), 32'd1);

    // FIFO full for three cycles mid-frame.
    clear_counts();
    frame(512, 0, 5000, 6000, 100, 3);
    idle(3);
    check_eq("t5_writes", 32'(wr_cnt), 32'd509);
    check_eq("t5_ovf",    32'(ovf_cnt), 32'd3);

    // Reset mid-frame: in-flight beats vanish, remainder is a fresh frame.
    clear_counts();
    for (int i = 0; i < 200; i++) step(0, 1, 0, 9000, 100, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    frame(400, 0, -300, 8000, -1, 0);
    idle(3);
    check_eq("t6_writes", 32'(wr_cnt), 32'd598);
    check_eq("t6_err",    32'(err_cnt), 32'd1);

    // Randomized frames with gaps, level, full and data.
    for (int f = 0; f < 12; f++) begin
      int len;
      int lvl;
      int k;
      len = (f % 3 == 0) ? 512 : int'($urandom_range(1, 700));
      lvl = int'($urandom_range(0, 1023));
      k   = 0;
      while (k < len) begin
        int re;
        int im;
        bit v;
        re = int'($urandom_range(0, 65535)) - 32768;
        im = ($urandom_range(0, 15) == 0) ? -32768 : int'($urandom_range(0, 65535)) - 32768;
        v  = ($urandom_range(0, 9) < 7);
        step(0, v, v && (k == len - 1), re, im,
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2047)) : lvl,
             $urandom_range(0, 9) == 0);
        if (v) k++;
      end
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
